// File: rtl/load_store_defs_pkg.sv
// Shared load/store definitions: LSOp encodings, load-aligner FSM states and
// access-size helpers used by both the load aligner and the store byte-enable logic.
package load_store_defs;

    typedef enum logic [1:0] {
        LS_FULL = 2'b00,
        LS_BYTE = 2'b01,
        LS_HALF = 2'b10,
        LS_WORD = 2'b11
    } ls_op_e;

    typedef enum logic [1:0] {
        LA_IDLE   = 2'b00,
        LA_FETCH0 = 2'b01,
        LA_FETCH1 = 2'b10,
        LA_HOLD   = 2'b11
    } la_state_e;

    // Bytes touched by an access; LS_FULL means the whole datapath word.
    function automatic int ls_nbytes(input logic [1:0] op, input int data_w);
        case (op)
            LS_BYTE: ls_nbytes = 1;
            LS_HALF: ls_nbytes = 2;
            LS_WORD: ls_nbytes = 4;
            default: ls_nbytes = data_w / 8;
        endcase
    endfunction

    function automatic logic ls_natural_mis(input int off, input logic [1:0] op, input int data_w);
        return (off % ls_nbytes(op, data_w)) != 0;
    endfunction

    function automatic logic ls_crossing(input int off, input logic [1:0] op, input int data_w);
        return (off + ls_nbytes(op, data_w)) > (data_w / 8);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational field extractor: shifts the two-word window down to the
// addressed byte offset, keeps the access-sized field and zero/sign extends it.
module load_extract
    import load_store_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] word1_i,
    input  logic [DATA_W-1:0] word0_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        op_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] data_o
);

    logic [2*DATA_W-1:0] dbl;
    logic [DATA_W-1:0]   shifted;
    int                  nbits;
    logic                fill;

    always_comb begin
        dbl     = {word1_i, word0_i};
        shifted = DATA_W'(dbl >> {off_i, 3'b000});
        nbits   = 8 * ls_nbytes(op_i, DATA_W);
        fill    = 1'b0;
        // Loop-select the sign bit so the index stays a constant per iteration.
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) fill = shifted[i] & ~uns_i;
        end
        data_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_o[i] = (i < nbits) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// Load-data aligner: one load in flight, fetches one or two memory beats,
// extracts and extends the addressed field, holds it under valid/ready.
module load_align_unit
    import load_store_defs::*;
#(
    parameter int DATA_W         = 32,
    parameter int OFF_W          = $clog2(DATA_W / 8),
    parameter int MISALIGN_SPLIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OFF_W-1:0]  req_addr,
    input  logic [1:0]        LSOp,
    input  logic              req_unsigned,
    output logic              mem_req,
    output logic              mem_second,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wd_out,
    output logic              misalign_err
);

    la_state_e         state_q, state_d;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        op_q;
    logic              uns_q;
    logic [DATA_W-1:0] word0_q;
    logic [DATA_W-1:0] wd_q;
    logic              err_q;

    logic              trap_in;
    logic              split_q;
    logic [DATA_W-1:0] ext_w1, ext_w0, ext_data;

    assign trap_in = (MISALIGN_SPLIT == 0) && ls_natural_mis(int'(req_addr), LSOp, DATA_W);
    assign split_q = (MISALIGN_SPLIT != 0) && ls_crossing(int'(off_q), op_q, DATA_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LA_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LA_IDLE:   if (req_valid) state_d = trap_in ? LA_HOLD : LA_FETCH0;
            LA_FETCH0: if (mem_ack)   state_d = split_q ? LA_FETCH1 : LA_HOLD;
            LA_FETCH1: if (mem_ack)   state_d = LA_HOLD;
            LA_HOLD:   if (out_ready) state_d = LA_IDLE;
            default:                  state_d = LA_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_second = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            LA_IDLE:   req_ready = 1'b1;
            LA_FETCH0: mem_req   = 1'b1;
            LA_FETCH1: begin
                mem_req    = 1'b1;
                mem_second = 1'b1;
            end
            LA_HOLD:   out_valid = 1'b1;
            default:   req_ready = 1'b0;
        endcase
    end

    // In FETCH0 the field never reaches the upper word, so it is zero-filled.
    assign ext_w1 = (state_q == LA_FETCH1) ? mem_rdata : '0;
    assign ext_w0 = (state_q == LA_FETCH1) ? word0_q   : mem_rdata;

    load_extract #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_extract (
        .word1_i (ext_w1),
        .word0_i (ext_w0),
        .off_i   (off_q),
        .op_i    (op_q),
        .uns_i   (uns_q),
        .data_o  (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q   <= '0;
            op_q    <= '0;
            uns_q   <= 1'b0;
            word0_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                LA_IDLE: if (req_valid) begin
                    off_q <= req_addr;
                    op_q  <= LSOp;
                    uns_q <= req_unsigned;
                    err_q <= trap_in;
                    wd_q  <= '0;
                end
                LA_FETCH0: if (mem_ack) begin
                    word0_q <= mem_rdata;
                    if (!split_q) wd_q <= ext_data;
                end
                LA_FETCH1: if (mem_ack) wd_q <= ext_data;
                default: ;
            endcase
        end
    end

    assign wd_out       = wd_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: a 32-bit split-mode instance and a 64-bit trap-mode
// instance, directed loads with a scoreboard monitor on the result handshake.
module tb_load_align_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rv0, rr0, ru0, mq0, ms0, ma0, ov0, or0, me0;
    logic [1:0]  ra0, op0;
    logic [31:0] md0, wd0;

    logic        rv1, rr1, ru1, mq1, ms1, ma1, ov1, or1, me1;
    logic [2:0]  ra1;
    logic [1:0]  op1;
    logic [63:0] md1, wd1;

    load_align_unit #(.DATA_W(32), .MISALIGN_SPLIT(1)) u32 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_addr(ra0),
        .LSOp(op0), .req_unsigned(ru0), .mem_req(mq0), .mem_second(ms0), .mem_ack(ma0),
        .mem_rdata(md0), .out_valid(ov0), .out_ready(or0), .wd_out(wd0), .misalign_err(me0)
    );

    load_align_unit #(.DATA_W(64), .MISALIGN_SPLIT(0)) u64 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_addr(ra1),
        .LSOp(op1), .req_unsigned(ru1), .mem_req(mq1), .mem_second(ms1), .mem_ack(ma1),
        .mem_rdata(md1), .out_valid(ov1), .out_ready(or1), .wd_out(wd1), .misalign_err(me1)
    );

    typedef struct packed { logic [63:0] d; logic e; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic logic [63:0] f_wd(input int s);  return (s == 0) ? {32'b0, wd0} : wd1; endfunction
    function automatic logic f_ov(input int s);   return (s == 0) ? ov0 : ov1; endfunction
    function automatic logic f_rdy(input int s);  return (s == 0) ? rr0 : rr1; endfunction
    function automatic logic f_mreq(input int s); return (s == 0) ? mq0 : mq1; endfunction
    function automatic logic f_msec(input int s); return (s == 0) ? ms0 : ms1; endfunction

    task automatic set_req(input int s, input logic v, input logic [2:0] a, input logic [1:0] op, input logic u);
        if (s == 0) begin rv0 = v; ra0 = a[1:0]; op0 = op; ru0 = u; end
        else        begin rv1 = v; ra1 = a;      op1 = op; ru1 = u; end
    endtask

    task automatic set_ack(input int s, input logic a, input logic [63:0] d);
        if (s == 0) begin ma0 = a; md0 = d[31:0]; end
        else        begin ma1 = a; md1 = d; end
    endtask

    task automatic set_ordy(input int s, input logic r);
        if (s == 0) or0 = r; else or1 = r;
    endtask

    // Scoreboard monitor: pops one expectation per completed output handshake.
    always begin : mon
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n && ov0 && or0) begin
            if (q0.size() == 0) begin n_chk++; $display("FAIL sb0_unexpected: got %h expected none", wd0); end
            else begin e = q0.pop_front(); chk("sb0_data", {32'b0, wd0}, e.d); chk("sb0_err", me0, e.e); end
        end
        if (rst_n && ov1 && or1) begin
            if (q1.size() == 0) begin n_chk++; $display("FAIL sb1_unexpected: got %h expected none", wd1); end
            else begin e = q1.pop_front(); chk("sb1_data", wd1, e.d); chk("sb1_err", me1, e.e); end
        end
    end

    task automatic run(input int s, input logic [2:0] a, input logic [1:0] op, input logic u,
                       input logic [63:0] w0, input logic [63:0] w1,
                       input logic [63:0] ed, input logic ee,
                       input int elat, input int ebeats, input bit stall);
        int lat;
        int beats;
        logic [63:0] held;
        exp_t e;
        e.d = ed;
        e.e = ee;
        if (s == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        chk("req_ready_idle", f_rdy(s), 1);
        set_req(s, 1'b1, a, op, u);
        set_ordy(s, !stall);
        @(negedge clk);
        set_req(s, 1'b0, 3'd0, 2'd0, 1'b0);
        lat = 0;
        beats = 0;
        for (int c = 1; c <= 20; c++) begin
            if (f_ov(s)) begin lat = c; break; end
            if (f_mreq(s)) begin
                beats++;
                chk("mem_second", f_msec(s), (beats == 2) ? 64'd1 : 64'd0);
                set_ack(s, 1'b1, f_msec(s) ? w1 : w0);
            end else begin
                set_ack(s, 1'b0, 64'd0);
            end
            @(negedge clk);
        end
        set_ack(s, 1'b0, 64'd0);
        chk("latency", lat, elat);
        chk("beats", beats, ebeats);
        if (stall) begin
            held = f_wd(s);
            set_req(s, 1'b1, a + 3'd1, ~op, ~u);
            repeat (5) begin
                @(negedge clk);
                chk("stall_valid", f_ov(s), 1);
                chk("stall_wd", f_wd(s), ed);
                chk("stall_stable", f_wd(s), held);
            end
            set_req(s, 1'b0, 3'd0, 2'd0, 1'b0);
            set_ordy(s, 1'b1);
        end
        @(negedge clk);
        chk("valid_drop", f_ov(s), 0);
        chk("ready_back", f_rdy(s), 1);
    endtask

    initial begin
        set_req(0, 1'b0, 3'd0, 2'd0, 1'b0);
        set_req(1, 1'b0, 3'd0, 2'd0, 1'b0);
        set_ack(0, 1'b0, 64'd0);
        set_ack(1, 1'b0, 64'd0);
        or0 = 1'b1;
        or1 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready0", rr0, 1);  chk("rst_mreq0", mq0, 0); chk("rst_msec0", ms0, 0);
        chk("rst_valid0", ov0, 0);  chk("rst_err0", me0, 0);  chk("rst_wd0", wd0, 0);
        chk("rst_ready1", rr1, 1);  chk("rst_valid1", ov1, 0); chk("rst_wd1", wd1, 0);

        // Stray ack while idle must be ignored.
        set_ack(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        set_ack(1, 1'b0, 64'd0);
        chk("stray_valid1", ov1, 0); chk("stray_mreq1", mq1, 0); chk("stray_ready1", rr1, 1);

        // 32-bit, split mode
        run(0, 3'd3, 2'b01, 1'b0, 64'h80FF_1234, 64'd0, 64'hFFFF_FF80, 1'b0, 2, 1, 1'b0);
        run(0, 3'd2, 2'b10, 1'b1, 64'h9ABC_0000, 64'd0, 64'h0000_9ABC, 1'b0, 2, 1, 1'b0);
        run(0, 3'd3, 2'b11, 1'b0, 64'h11AB_CDEF, 64'h0033_2222, 64'h3322_2211, 1'b0, 3, 2, 1'b0);
        run(0, 3'd1, 2'b10, 1'b0, 64'h1280_0134, 64'd0, 64'hFFFF_8001, 1'b0, 2, 1, 1'b0);
        run(0, 3'd3, 2'b10, 1'b0, 64'hAB00_0000, 64'h0000_00CD, 64'hFFFF_CDAB, 1'b0, 3, 2, 1'b0);
        run(0, 3'd1, 2'b01, 1'b1, 64'h0000_F500, 64'd0, 64'h0000_00F5, 1'b0, 2, 1, 1'b0);
        run(0, 3'd0, 2'b00, 1'b0, 64'hDEAD_BEEF, 64'd0, 64'hDEAD_BEEF, 1'b0, 2, 1, 1'b0);
        run(0, 3'd0, 2'b11, 1'b1, 64'h8765_4321, 64'd0, 64'h8765_4321, 1'b0, 2, 1, 1'b0);
        run(0, 3'd0, 2'b01, 1'b0, 64'h0000_007F, 64'd0, 64'h0000_007F, 1'b0, 2, 1, 1'b1);

        // 64-bit, trap mode
        run(1, 3'd1, 2'b11, 1'b0, 64'h1111_2222_3333_4444, 64'd0, 64'd0, 1'b1, 1, 0, 1'b0);
        run(1, 3'd4, 2'b11, 1'b0, 64'h8000_0001_DEAD_BEEF, 64'd0, 64'hFFFF_FFFF_8000_0001, 1'b0, 2, 1, 1'b0);
        run(1, 3'd0, 2'b00, 1'b0, 64'h8000_0001_DEAD_BEEF, 64'd0, 64'h8000_0001_DEAD_BEEF, 1'b0, 2, 1, 1'b0);
        run(1, 3'd4, 2'b11, 1'b1, 64'h8000_0001_DEAD_BEEF, 64'd0, 64'h0000_0000_8000_0001, 1'b0, 2, 1, 1'b0);
        run(1, 3'd3, 2'b10, 1'b0, 64'h1111_2222_3333_4444, 64'd0, 64'd0, 1'b1, 1, 0, 1'b1);
        run(1, 3'd7, 2'b01, 1'b0, 64'hF000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 2, 1, 1'b0);
        run(1, 3'd6, 2'b10, 1'b1, 64'hBEEF_0000_0000_0000, 64'd0, 64'h0000_0000_0000_BEEF, 1'b0, 2, 1, 1'b0);
        run(1, 3'd4, 2'b00, 1'b0, 64'h1111_2222_3333_4444, 64'd0, 64'd0, 1'b1, 1, 0, 1'b0);

        // Reset while FETCH0 is waiting, then a late ack.
        @(negedge clk);
        set_req(0, 1'b1, 3'd0, 2'b11, 1'b0);
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 2'd0, 1'b0);
        chk("f0_mreq", mq0, 1);
        chk("f0_msec", ms0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", rr0, 1);
        chk("midrst_mreq", mq0, 0);
        chk("midrst_valid", ov0, 0);
        rst_n = 1'b1;
        set_ack(0, 1'b1, 64'h5555_5555);
        @(negedge clk);
        set_ack(0, 1'b0, 64'd0);
        chk("late_ack_valid", ov0, 0);
        chk("late_ack_ready", rr0, 1);
        chk("late_ack_mreq", mq0, 0);
        @(negedge clk);
        chk("late_ack_valid2", ov0, 0);
        run(0, 3'd0, 2'b10, 1'b1, 64'h1234_FFFE, 64'd0, 64'h0000_FFFE, 1'b0, 2, 1, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drain", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
